// File: rtl/hyperram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single HyperRAM controller port.
// Read return routing uses an in-order tag FIFO that records which requester issued each read.
module hyperram_port_arbiter #(
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MAX_RD = 4
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,

  output logic              err_unexpected_rd
);

  localparam int unsigned PtrW = $clog2(MAX_RD);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [MAX_RD-1:0] tag_q;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0] s_address_q, s_address_d;
  logic [DATA_W-1:0] s_writedata_q, s_writedata_d;
  logic              s_read_q, s_read_d;
  logic              s_write_q, s_write_d;

  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              err_q, err_d;

  logic full, empty;
  logic elig0, elig1;
  logic grant, grant_id, grant_rd;
  logic push, pop, pop_id;

  // Read eligibility looks at occupancy at the start of the cycle; a same-cycle pop does not help.
  always_comb begin
    full     = (cnt_q == CntW'(MAX_RD));
    empty    = (cnt_q == '0);
    elig0    = m0_read ? !full : m0_write;
    elig1    = m1_read ? !full : m1_write;
    grant    = (state_q == StIdle) && rstn && (elig0 || elig1);
    grant_id = (elig0 && elig1) ? ~last_q : elig1;
    grant_rd = grant_id ? m1_read : m0_read;
    push     = grant && grant_rd;
    pop      = s_readdatavalid && !empty;
    pop_id   = tag_q[rd_ptr_q];
  end

  assign m0_waitrequest = !(grant && !grant_id);
  assign m1_waitrequest = !(grant && grant_id);

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    s_address_d   = s_address_q;
    s_writedata_d = s_writedata_q;
    s_read_d      = s_read_q;
    s_write_d     = s_write_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d       = StHold;
          last_d        = grant_id;
          s_address_d   = grant_id ? m1_address : m0_address;
          s_writedata_d = grant_id ? m1_writedata : m0_writedata;
          s_read_d      = grant_rd;
          s_write_d     = !grant_rd;
        end
      end
      StHold: begin
        if (!s_waitrequest) begin
          state_d   = StIdle;
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    rvalid0_d = pop && !pop_id;
    rvalid1_d = pop && pop_id;
    rdata0_d  = (pop && !pop_id) ? s_readdata : rdata0_q;
    rdata1_d  = (pop && pop_id) ? s_readdata : rdata1_q;
    // Returns with nothing outstanding are dropped and latched as an error.
    err_d     = err_q | (s_readdatavalid & empty);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      last_q        <= 1'b1;
      tag_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      s_address_q   <= '0;
      s_writedata_q <= '0;
      s_read_q      <= 1'b0;
      s_write_q     <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      if (push) begin
        tag_q[wr_ptr_q] <= grant_id;
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      s_address_q   <= s_address_d;
      s_writedata_q <= s_writedata_d;
      s_read_q      <= s_read_d;
      s_write_q     <= s_write_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      err_q         <= err_d;
    end
  end

  assign s_address         = s_address_q;
  assign s_writedata       = s_writedata_q;
  assign s_read            = s_read_q;
  assign s_write           = s_write_q;
  assign m0_readdatavalid  = rvalid0_q;
  assign m1_readdatavalid  = rvalid1_q;
  assign m0_readdata       = rdata0_q;
  assign m1_readdata       = rdata1_q;
  assign err_unexpected_rd = err_q;

endmodule

// File: tb/tb_hyperram_port_arbiter.sv
// Bench for hyperram_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (grant choice, downstream command, in-order read routing).
module tb_hyperram_port_arbiter;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MAX_RD = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              s_read, s_write, s_waitrequest, s_readdatavalid;
  logic              err_unexpected_rd;

  hyperram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD)) dut (
    .clk(clk), .rstn(rstn),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .err_unexpected_rd(err_unexpected_rd)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int slave_lat = 3;
  bit slave_en = 1'b0;
  bit inj = 1'b0;
  logic [DATA_W-1:0] inj_data = '0;
  int due_q[$];

  // Called at a negedge: samples downstream acceptance, then moves to posedge+1 and drives
  // the downstream read-return side (slave model or an injected stray pulse).
  task automatic adv();
    if (slave_en && rstn && s_read && !s_waitrequest) due_q.push_back(cyc + slave_lat);
    @(posedge clk);
    #1;
    cyc++;
    s_readdatavalid = 1'b0;
    if (!rstn) due_q.delete();
    else if (slave_en && due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      s_readdatavalid = 1'b1;
      s_readdata = DATA_W'($urandom);
    end
    if (inj) begin
      s_readdatavalid = 1'b1;
      s_readdata = inj_data;
      inj = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    adv();
  endtask

  task automatic clear_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    s_waitrequest = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    slave_en = 0;
    rstn = 0;
    tick();
    tick();
    rstn = 1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    s_readdatavalid = 0; s_readdata = '0;
    rstn = 0;
    m0_write = 1; m1_read = 1; m0_address = 22'h155; m1_address = 22'h2AA;
    m0_writedata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_cmp++; if (m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_m0_wait got %b exp 1", m0_waitrequest); end
    n_cmp++; if (m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_m1_wait got %b exp 1", m1_waitrequest); end
    n_cmp++; if ({s_read, s_write} !== 2'b00) begin n_err++; $display("FAIL rst_s_cmd got %b exp 00", {s_read, s_write}); end
    n_cmp++; if (s_address !== '0) begin n_err++; $display("FAIL rst_s_address got %h exp 0", s_address); end
    n_cmp++; if (s_writedata !== '0) begin n_err++; $display("FAIL rst_s_writedata got %h exp 0", s_writedata); end
    n_cmp++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin n_err++; $display("FAIL rst_rdv got %b exp 00", {m0_readdatavalid, m1_readdatavalid}); end
    n_cmp++; if (m0_readdata !== '0 || m1_readdata !== '0) begin n_err++; $display("FAIL rst_readdata got %h/%h exp 0/0", m0_readdata, m1_readdata); end
    n_cmp++; if (err_unexpected_rd !== 1'b0) begin n_err++; $display("FAIL rst_err got %b exp 0", err_unexpected_rd); end
    adv();
    clear_inputs();
    rstn = 1;
    @(negedge clk);
    n_cmp++; if ({m0_waitrequest, m1_waitrequest, s_read, s_write} !== 4'b1100) begin n_err++; $display("FAIL rst_idle got %b exp 1100", {m0_waitrequest, m1_waitrequest, s_read, s_write}); end
    adv();
  endtask

  task automatic test_single_write();
    do_reset();
    m0_write = 1; m0_address = 22'h000010; m0_writedata = 32'hDEADBEEF; s_waitrequest = 0;
    @(negedge clk);
    n_cmp++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin n_err++; $display("FAIL wr_grant got %b exp 01", {m0_waitrequest, m1_waitrequest}); end
    n_cmp++; if (s_write !== 1'b0) begin n_err++; $display("FAIL wr_s_write_early got %b exp 0", s_write); end
    adv();
    m0_write = 0;
    @(negedge clk);
    n_cmp++; if ({s_write, s_read, s_address, s_writedata} !== {2'b10, 22'h000010, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL wr_s_cmd got %b%b %h %h exp 10 000010 deadbeef", s_write, s_read, s_address, s_writedata);
    end
    n_cmp++; if (m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL wr_m0_wait_hold got %b exp 1", m0_waitrequest); end
    adv();
    @(negedge clk);
    n_cmp++; if (s_write !== 1'b0) begin n_err++; $display("FAIL wr_s_write_len got %b exp 0", s_write); end
    adv();
  endtask

  task automatic test_contention();
    int gid[$];
    int rid[$];
    logic [DATA_W-1:0] rdat[$];
    logic [DATA_W-1:0] sdat[$];
    do_reset();
    slave_en = 1; slave_lat = 3;
    m0_read = 1; m1_read = 1; m0_address = 22'h000100; m1_address = 22'h000200;
    for (int c = 0; c < 40; c++) begin
      if (c == 24) begin m0_read = 0; m1_read = 0; end
      @(negedge clk);
      if (!m0_waitrequest) gid.push_back(0);
      if (!m1_waitrequest) gid.push_back(1);
      if (m0_readdatavalid) begin rid.push_back(0); rdat.push_back(m0_readdata); end
      if (m1_readdatavalid) begin rid.push_back(1); rdat.push_back(m1_readdata); end
      if (s_readdatavalid) sdat.push_back(s_readdata);
      adv();
    end
    n_cmp++; if (gid.size() < 8) begin n_err++; $display("FAIL cont_grants got %0d exp >=8", gid.size()); end
    for (int k = 0; k < gid.size(); k++) begin
      n_cmp++; if (gid[k] != k % 2) begin n_err++; $display("FAIL cont_grant_order[%0d] got m%0d exp m%0d", k, gid[k], k % 2); end
    end
    n_cmp++; if (rid.size() != gid.size()) begin n_err++; $display("FAIL cont_returns got %0d exp %0d", rid.size(), gid.size()); end
    for (int k = 0; k < rid.size() && k < gid.size() && k < sdat.size(); k++) begin
      n_cmp++; if (rid[k] != gid[k] || rdat[k] !== sdat[k]) begin
        n_err++; $display("FAIL cont_route[%0d] got m%0d %h exp m%0d %h", k, rid[k], rdat[k], gid[k], sdat[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m0_write = 1; m0_address = 22'h0ABCDE; m0_writedata = 32'h12345678; s_waitrequest = 1;
    @(negedge clk);
    n_cmp++; if (m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL bp_grant got %b exp 0", m0_waitrequest); end
    adv();
    m0_write = 0; m1_write = 1; m1_address = 22'h3F0001; m1_writedata = 32'hCAFEF00D;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if ({s_write, s_read, s_address, s_writedata} !== {2'b10, 22'h0ABCDE, 32'h12345678}) begin
        n_err++; $display("FAIL bp_stable[%0d] got %b%b %h %h exp 10 0abcde 12345678", c, s_write, s_read, s_address, s_writedata);
      end
      n_cmp++; if (m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL bp_m1_held[%0d] got %b exp 1", c, m1_waitrequest); end
      adv();
    end
    s_waitrequest = 0;
    @(negedge clk);
    n_cmp++; if ({s_write, m1_waitrequest} !== 2'b11) begin n_err++; $display("FAIL bp_accept_cycle got %b exp 11", {s_write, m1_waitrequest}); end
    adv();
    @(negedge clk);
    n_cmp++; if ({s_write, m1_waitrequest} !== 2'b00) begin n_err++; $display("FAIL bp_idle_grant got %b exp 00", {s_write, m1_waitrequest}); end
    adv();
    m1_write = 0;
    @(negedge clk);
    n_cmp++; if ({s_write, s_address, s_writedata} !== {1'b1, 22'h3F0001, 32'hCAFEF00D}) begin
      n_err++; $display("FAIL bp_second_cmd got %b %h %h exp 1 3f0001 cafef00d", s_write, s_address, s_writedata);
    end
    adv();
    tick();
  endtask

  task automatic test_fifo_full();
    int g0 = 0;
    int g1 = 0;
    do_reset();
    m0_read = 1; m0_address = 22'h000040; m1_address = 22'h000080; m1_writedata = 32'h0F0F0F0F;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (!m0_waitrequest) g0++;
      if (!m1_waitrequest) g1++;
      adv();
      m1_write = (g0 >= 4 && g1 == 0);
    end
    n_cmp++; if (g0 != 4) begin n_err++; $display("FAIL full_m0_reads got %0d exp 4", g0); end
    n_cmp++; if (g1 != 1) begin n_err++; $display("FAIL full_m1_write got %0d exp 1", g1); end
    inj = 1; inj_data = 32'h0BADF00D;
    @(negedge clk);
    n_cmp++; if (m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL full_held got %b exp 1", m0_waitrequest); end
    adv();
    @(negedge clk);
    n_cmp++; if (m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL full_return_cycle got %b exp 1", m0_waitrequest); end
    adv();
    @(negedge clk);
    n_cmp++; if (m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL full_grant_after_pop got %b exp 0", m0_waitrequest); end
    n_cmp++; if ({m0_readdatavalid, m1_readdatavalid, m0_readdata} !== {2'b10, 32'h0BADF00D}) begin
      n_err++; $display("FAIL full_return got %b%b %h exp 10 0badf00d", m0_readdatavalid, m1_readdatavalid, m0_readdata);
    end
    adv();
    m0_read = 0;
  endtask

  task automatic test_stray();
    do_reset();
    inj = 1; inj_data = 32'h5555AAAA;
    tick();
    @(negedge clk);
    n_cmp++; if (err_unexpected_rd !== 1'b0) begin n_err++; $display("FAIL stray_err_early got %b exp 0", err_unexpected_rd); end
    adv();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if ({err_unexpected_rd, m0_readdatavalid, m1_readdatavalid} !== 3'b100) begin
        n_err++; $display("FAIL stray_sticky[%0d] got %b exp 100", c, {err_unexpected_rd, m0_readdatavalid, m1_readdatavalid});
      end
      adv();
    end
    rstn = 0;
    @(negedge clk);
    n_cmp++; if (err_unexpected_rd !== 1'b0) begin n_err++; $display("FAIL stray_clear got %b exp 0", err_unexpected_rd); end
    adv();
    rstn = 1;
    tick();
  endtask

  task automatic test_reset_mid();
    int g = 0;
    int n0 = 0;
    int n1 = 0;
    logic [DATA_W-1:0] exp_d = '0;
    logic [DATA_W-1:0] got_d = '0;
    do_reset();
    m0_read = 1; m0_address = 22'h000777;
    for (int c = 0; c < 12 && g < 2; c++) begin
      @(negedge clk);
      if (!m0_waitrequest) g++;
      adv();
      if (g == 2) begin m0_read = 0; s_waitrequest = 1; end
    end
    n_cmp++; if (g != 2) begin n_err++; $display("FAIL mid_reads got %0d exp 2", g); end
    @(negedge clk);
    n_cmp++; if (s_read !== 1'b1) begin n_err++; $display("FAIL mid_hold got %b exp 1", s_read); end
    adv();
    rstn = 0;
    @(negedge clk);
    n_cmp++; if ({s_read, s_write, m0_readdatavalid, m1_readdatavalid, err_unexpected_rd, m0_waitrequest, m1_waitrequest} !== 7'b0000011) begin
      n_err++; $display("FAIL mid_rst_ctrl got %b exp 0000011", {s_read, s_write, m0_readdatavalid, m1_readdatavalid, err_unexpected_rd, m0_waitrequest, m1_waitrequest});
    end
    n_cmp++; if (s_address !== '0 || s_writedata !== '0) begin n_err++; $display("FAIL mid_rst_data got %h %h exp 0 0", s_address, s_writedata); end
    adv();
    rstn = 1; s_waitrequest = 0; slave_en = 1; slave_lat = 3;
    m1_read = 1; m1_address = 22'h001234;
    @(negedge clk);
    n_cmp++; if (m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL mid_m1_grant got %b exp 0", m1_waitrequest); end
    adv();
    m1_read = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s_readdatavalid) exp_d = s_readdata;
      if (m0_readdatavalid) n0++;
      if (m1_readdatavalid) begin n1++; got_d = m1_readdata; end
      adv();
    end
    n_cmp++; if (n0 != 0 || n1 != 1) begin n_err++; $display("FAIL mid_route got m0=%0d m1=%0d exp m0=0 m1=1", n0, n1); end
    n_cmp++; if (got_d !== exp_d) begin n_err++; $display("FAIL mid_data got %h exp %h", got_d, exp_d); end
    n_cmp++; if (err_unexpected_rd !== 1'b0) begin n_err++; $display("FAIL mid_err got %b exp 0", err_unexpected_rd); end
  endtask

  // Transaction-level model: one downstream command in flight at a time, round-robin choice
  // among eligible requesters, and an ordered list of outstanding read owners.
  task automatic test_random();
    bit busy = 0;
    int last = 1;
    int owners[$];
    bit c_rd = 0;
    logic [ADDR_W-1:0] c_addr = '0;
    logic [DATA_W-1:0] c_data = '0;
    bit exp_v0 = 0;
    bit exp_v1 = 0;
    logic [DATA_W-1:0] exp_d = '0;
    bit exp_err = 0;
    bit e0, e1;
    int g;
    do_reset();
    slave_en = 1; slave_lat = 9;
    for (int c = 0; c < 600; c++) begin
      m0_read = ($urandom_range(0, 2) == 0); m0_write = ($urandom_range(0, 2) == 0);
      m1_read = ($urandom_range(0, 2) == 0); m1_write = ($urandom_range(0, 2) == 0);
      m0_address = ADDR_W'($urandom); m1_address = ADDR_W'($urandom);
      m0_writedata = DATA_W'($urandom); m1_writedata = DATA_W'($urandom);
      s_waitrequest = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n_cmp++; if ({m0_readdatavalid, m1_readdatavalid} !== {exp_v0, exp_v1}) begin
        n_err++; $display("FAIL rnd_rdv[%0d] got %b%b exp %b%b", c, m0_readdatavalid, m1_readdatavalid, exp_v0, exp_v1);
      end
      if (exp_v0) begin
        n_cmp++; if (m0_readdata !== exp_d) begin n_err++; $display("FAIL rnd_rd0[%0d] got %h exp %h", c, m0_readdata, exp_d); end
      end
      if (exp_v1) begin
        n_cmp++; if (m1_readdata !== exp_d) begin n_err++; $display("FAIL rnd_rd1[%0d] got %h exp %h", c, m1_readdata, exp_d); end
      end
      n_cmp++; if (err_unexpected_rd !== exp_err) begin n_err++; $display("FAIL rnd_err[%0d] got %b exp %b", c, err_unexpected_rd, exp_err); end
      if (busy) begin
        n_cmp++; if ({s_read, s_write, s_address, s_writedata} !== {c_rd, !c_rd, c_addr, c_data}) begin
          n_err++; $display("FAIL rnd_cmd[%0d] got %b%b %h %h exp %b%b %h %h", c, s_read, s_write, s_address, s_writedata, c_rd, !c_rd, c_addr, c_data);
        end
      end else begin
        n_cmp++; if ({s_read, s_write} !== 2'b00) begin n_err++; $display("FAIL rnd_idle[%0d] got %b%b exp 00", c, s_read, s_write); end
      end
      g = -1;
      if (!busy) begin
        e0 = m0_read ? (owners.size() < MAX_RD) : m0_write;
        e1 = m1_read ? (owners.size() < MAX_RD) : m1_write;
        if (e0 && e1) g = (last == 0) ? 1 : 0;
        else if (e0) g = 0;
        else if (e1) g = 1;
      end
      n_cmp++; if ({m0_waitrequest, m1_waitrequest} !== {g != 0, g != 1}) begin
        n_err++; $display("FAIL rnd_grant[%0d] got %b%b exp %b%b", c, m0_waitrequest, m1_waitrequest, g != 0, g != 1);
      end
      exp_v0 = 0; exp_v1 = 0;
      if (s_readdatavalid) begin
        if (owners.size() > 0) begin
          if (owners.pop_front() == 0) exp_v0 = 1; else exp_v1 = 1;
          exp_d = s_readdata;
        end else exp_err = 1;
      end
      if (busy && !s_waitrequest) busy = 0;
      if (g >= 0) begin
        busy = 1; last = g;
        c_rd = (g == 0) ? m0_read : m1_read;
        c_addr = (g == 0) ? m0_address : m1_address;
        c_data = (g == 0) ? m0_writedata : m1_writedata;
        if (c_rd) owners.push_back(g);
      end
      adv();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    s_readdatavalid = 0;
    s_readdata = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_backpressure();
    test_fifo_full();
    test_stray();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hyperram_port_arbiter.md
HYPERRAM_PORT_ARBITER -- requirements
Module: hyperram_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 22, word address width; DATA_W, default 32, data width; MAX_RD, default 4, read-tag FIFO depth (power of two, at least 2).
REQ-002 SHALL have port: clk  in  1  single clock; all logic rising-edge.
REQ-003 SHALL have port: rstn  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: m0_address, m1_address  in  ADDR_W  requester word address.
REQ-005 SHALL have ports: m0_read, m0_write, m1_read, m1_write  in  1  requester command strobes.
REQ-006 SHALL have ports: m0_writedata, m1_writedata  in  DATA_W  requester write data.
REQ-007 SHALL have ports: m0_waitrequest, m1_waitrequest  out  1  requester stall; a command is accepted when it is asserted and waitrequest is low.
REQ-008 SHALL have ports: m0_readdata, m1_readdata  out  DATA_W  and m0_readdatavalid, m1_readdatavalid  out  1  returned read data.
REQ-009 SHALL have ports: s_address  out  ADDR_W;  s_read, s_write  out  1;  s_writedata  out  DATA_W  downstream command to the HyperRAM controller s0 port.
REQ-010 SHALL have ports: s_waitrequest  in  1  downstream stall;  s_readdata  in  DATA_W;  s_readdatavalid  in  1  downstream read return.
REQ-011 SHALL have port: err_unexpected_rd  out  1  sticky flag for read data returned with no outstanding tag.

Function
REQ-012 SHALL implement an FSM with states IDLE and HOLD.
REQ-013 In IDLE, a requester is eligible when its read or write is asserted; a read is eligible only when the tag FIFO is not full at the start of the cycle.
REQ-014 With both requesters eligible, grant SHALL go to the one not granted last (round-robin); after reset, m0 has priority.
REQ-015 In IDLE, the granted requester SHALL see waitrequest low combinationally for that cycle only; every other requester and state SHALL see waitrequest high.
REQ-016 On grant, address, writedata and command SHALL be registered to s_*; s_read or s_write SHALL assert the next cycle; FSM SHALL go to HOLD.
REQ-017 On a granted read, the requester ID SHALL be pushed to the tag FIFO in the grant cycle.
REQ-018 If read and write are both asserted by one requester, it SHALL be treated as a read and the write ignored.
REQ-019 In HOLD, s_* SHALL stay stable until a rising edge with s_waitrequest low; s_read/s_write SHALL then deassert and FSM SHALL return to IDLE (minimum 1 idle cycle between downstream commands).
REQ-020 On s_readdatavalid with the FIFO non-empty, the head SHALL pop; one cycle later the matching mX_readdatavalid SHALL pulse with mX_readdata equal to the captured s_readdata.
REQ-021 Simultaneous push and pop SHALL both take effect; the occupancy count (0..MAX_RD) SHALL be unchanged.
REQ-022 On s_readdatavalid with an empty FIFO, the data SHALL be dropped, no mX_readdatavalid SHALL pulse, and err_unexpected_rd SHALL set and hold until reset.
REQ-023 FIFO pointers SHALL wrap modulo MAX_RD; tag order SHALL be preserved across wrap.
REQ-024 A requester deasserting its command while waitrequest is high SHALL not be granted and SHALL leave no state.

Reset
REQ-025 While rstn is low: FSM SHALL be IDLE, FIFO SHALL be empty, last-grant SHALL be m1 (so m0 wins first); s_read, s_write, mX_readdatavalid and err_unexpected_rd SHALL be 0; s_address, s_writedata and mX_readdata SHALL be 0; mX_waitrequest SHALL be 1.
REQ-026 Reset asserted mid-HOLD or with reads outstanding SHALL discard the command and all tags; read data returned after reset release SHALL be handled per REQ-022.

Verification
REQ-027 Single-port write: m0_write, address 0x000010, data 0xDEADBEEF, s_waitrequest low -> m0_waitrequest low for 1 cycle, s_write high exactly 1 cycle later with matching address and data.
REQ-028 Contention: m0 and m1 both read continuously -> grants alternate m0, m1, m0, m1; returns at 3-cycle latency route in order to m0, m1, m0, m1.
REQ-029 Backpressure: s_waitrequest high for 5 cycles during HOLD -> s_* stable for all 5 cycles; a new grant occurs no earlier than 1 cycle after acceptance.
REQ-030 FIFO full: MAX_RD=4 reads issued with no returns -> a 5th read is held off (waitrequest high) while a write from the other port is still granted; the 5th read is granted in the cycle after the first return.
REQ-031 Stray return: s_readdatavalid pulse with nothing outstanding -> no mX_readdatavalid pulse, err_unexpected_rd goes to 1 and stays 1 until rstn is asserted.
REQ-032 Reset mid-operation: rstn pulsed low during HOLD with 2 reads outstanding -> all outputs at REQ-025 values; the next m1 read is granted normally and its data returns to m1.
